memops_tracker: RTL and testbench

- Synthesizable tracker for the ZipCPU pipelined memory interface.
- Keeps an in-order FIFO of outstanding bus operations and their destination registers, giving the CPU register-hazard and pending-PC/CC indications.
- Checks each return against the expected register and op type, and latches a sticky protocol-violation code.
- Sits between the CPU issue stage and any pipelined memory unit; it generalises the single-outstanding assumption to a parametrised depth.

---
 rtl/memops_tracker.sv | 140 ++++++++++++++
 tb/tb_memops_tracker.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/memops_tracker.sv
// rtl/memops_tracker.sv - in-order tracker of outstanding pipelined memory operations
// Provides register-hazard / pending-PC indications and latches the first protocol violation.
module memops_tracker #(
  parameter int LGDEPTH  = 3,
  parameter int REGW     = 5,
  parameter bit OPT_LOCK = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_stb,
  input  logic               i_op_read,
  input  logic [REGW-1:0]    i_oreg,
  input  logic               i_lock,
  input  logic               i_done,
  input  logic               i_valid,
  input  logic               i_err,
  input  logic [REGW-1:0]    i_wreg,
  input  logic [REGW-1:0]    i_chk_reg,
  output logic               o_stall,
  output logic [LGDEPTH:0]   o_outstanding,
  output logic               o_busy,
  output logic               o_rdbusy,
  output logic               o_read_cycle,
  output logic               o_hazard,
  output logic               o_pc_pending,
  output logic [REGW-1:0]    o_last_reg,
  output logic               o_violation,
  output logic [2:0]         o_vcode
);

  localparam int DEPTH = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] FULL = (LGDEPTH+1)'(DEPTH);

  // Each entry is {is_read, oreg}; vld marks slots holding an outstanding op.
  logic [REGW:0]      mem [DEPTH];
  logic [DEPTH-1:0]   vld;
  logic [LGDEPTH-1:0] wr_ptr, rd_ptr;
  logic [LGDEPTH:0]   count, count_next;
  logic               err_q;
  logic               accept, pop;
  logic               head_read;
  logic [REGW-1:0]    head_reg;
  logic [2:0]         vcode_next;

  assign o_stall       = (count == FULL);
  assign o_outstanding = count;
  assign o_busy        = (count != '0);
  assign o_rdbusy      = o_busy && o_read_cycle;
  assign accept        = i_stb && !o_stall && !i_err;
  assign pop           = i_done && !i_err && o_busy;
  assign head_read     = mem[rd_ptr][REGW];
  assign head_reg      = mem[rd_ptr][REGW-1:0];

  always_comb begin
    count_next = count;
    if (accept && !pop)
      count_next = count + 1'b1;
    else if (pop && !accept)
      count_next = count - 1'b1;
  end

  always_comb begin
    o_hazard     = 1'b0;
    o_pc_pending = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && mem[i][REGW]) begin
        if (mem[i][REGW-1:0] == i_chk_reg)
          o_hazard = 1'b1;
        if (mem[i][3:1] == 3'h7)
          o_pc_pending = 1'b1;
      end
    end
  end

  // Evaluated highest code first so the lowest firing code ends up selected.
  always_comb begin
    vcode_next = 3'd0;
    if (i_stb && err_q)
      vcode_next = 3'd7;
    if ((i_valid && !i_done) || (i_stb && o_pc_pending))
      vcode_next = 3'd6;
    if (i_stb && o_busy && (i_op_read != o_read_cycle))
      vcode_next = 3'd5;
    if ((i_done || i_err) && (count == '0))
      vcode_next = 3'd4;
    if (pop && !head_read && i_valid)
      vcode_next = 3'd3;
    if (pop && head_read && (!i_valid || (i_wreg != head_reg)))
      vcode_next = 3'd2;
    if (i_stb && o_stall)
      vcode_next = 3'd1;
  end

  always_ff @(posedge i_clk) begin
    if (accept && !i_reset)
      mem[wr_ptr] <= {i_op_read, i_oreg};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      count        <= '0;
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      vld          <= '0;
      err_q        <= 1'b0;
      o_read_cycle <= 1'b0;
      o_last_reg   <= '0;
      o_violation  <= 1'b0;
      o_vcode      <= 3'd0;
    end else begin
      err_q <= i_err;
      if (!o_violation && (vcode_next != 3'd0)) begin
        o_violation <= 1'b1;
        o_vcode     <= vcode_next;
      end
      if (i_err) begin
        count        <= '0;
        wr_ptr       <= '0;
        rd_ptr       <= '0;
        vld          <= '0;
        o_read_cycle <= 1'b0;
      end else begin
        count <= count_next;
        if (accept) begin
          wr_ptr       <= wr_ptr + 1'b1;
          vld[wr_ptr]  <= 1'b1;
          o_last_reg   <= i_oreg;
          o_read_cycle <= i_op_read;
        end else if ((count_next == '0) && !(OPT_LOCK && i_lock)) begin
          o_read_cycle <= 1'b0;
        end
        if (pop) begin
          rd_ptr      <= rd_ptr + 1'b1;
          vld[rd_ptr] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_memops_tracker.sv
// tb/tb_memops_tracker.sv - directed self-checking bench for memops_tracker
// Uses a depth-4 instance so the full/stall boundary is reached quickly.
module tb_memops_tracker;

  logic       i_clk = 1'b0;
  logic       i_reset, i_stb, i_op_read, i_lock, i_done, i_valid, i_err;
  logic [4:0] i_oreg, i_wreg, i_chk_reg;
  logic       o_stall, o_busy, o_rdbusy, o_read_cycle, o_hazard, o_pc_pending, o_violation;
  logic [2:0] o_outstanding;
  logic [4:0] o_last_reg;
  logic [2:0] o_vcode;

  int n_pass = 0;
  int n_total = 0;

  memops_tracker #(.LGDEPTH(2), .REGW(5), .OPT_LOCK(1'b0)) dut (
    .i_clk(i_clk), .i_reset(i_reset), .i_stb(i_stb), .i_op_read(i_op_read),
    .i_oreg(i_oreg), .i_lock(i_lock), .i_done(i_done), .i_valid(i_valid),
    .i_err(i_err), .i_wreg(i_wreg), .i_chk_reg(i_chk_reg),
    .o_stall(o_stall), .o_outstanding(o_outstanding), .o_busy(o_busy),
    .o_rdbusy(o_rdbusy), .o_read_cycle(o_read_cycle), .o_hazard(o_hazard),
    .o_pc_pending(o_pc_pending), .o_last_reg(o_last_reg),
    .o_violation(o_violation), .o_vcode(o_vcode)
  );

  always #5 i_clk = ~i_clk;

  task automatic tick;
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle;
    i_stb = 0; i_op_read = 0; i_oreg = 0; i_lock = 0; i_done = 0;
    i_valid = 0; i_err = 0; i_wreg = 0; i_chk_reg = 0;
  endtask

  task automatic do_reset;
    idle();
    i_reset = 1;
    tick(); tick();
    i_reset = 0;
  endtask

  task automatic test_reset;
    idle();
    i_reset = 1; i_stb = 1; i_op_read = 1; i_oreg = 5'd9;
    tick(); tick();
    i_reset = 0; idle();
    #1;
    n_total++; if (o_outstanding !== 3'd0) $display("FAIL rst_count got=%0d exp=0", o_outstanding); else n_pass++;
    n_total++; if (o_busy !== 1'b0 || o_stall !== 1'b0 || o_rdbusy !== 1'b0) $display("FAIL rst_flags got=%b%b%b exp=000", o_busy, o_stall, o_rdbusy); else n_pass++;
    n_total++; if (o_read_cycle !== 1'b0 || o_last_reg !== 5'd0) $display("FAIL rst_rc_last got=%b/%0d exp=0/0", o_read_cycle, o_last_reg); else n_pass++;
    n_total++; if (o_hazard !== 1'b0 || o_pc_pending !== 1'b0) $display("FAIL rst_haz got=%b%b exp=00", o_hazard, o_pc_pending); else n_pass++;
    n_total++; if (o_violation !== 1'b0 || o_vcode !== 3'd0) $display("FAIL rst_viol got=%b/%0d exp=0/0", o_violation, o_vcode); else n_pass++;
  endtask

  task automatic test_single_read;
    do_reset();
    i_stb = 1; i_op_read = 1; i_oreg = 5'd3;
    tick();
    idle(); i_chk_reg = 5'd3; #1;
    n_total++; if (o_outstanding !== 3'd1) $display("FAIL sr_count1 got=%0d exp=1", o_outstanding); else n_pass++;
    n_total++; if (o_hazard !== 1'b1) $display("FAIL sr_haz_r3 got=%b exp=1", o_hazard); else n_pass++;
    n_total++; if (o_rdbusy !== 1'b1 || o_last_reg !== 5'd3) $display("FAIL sr_rdbusy_last got=%b/%0d exp=1/3", o_rdbusy, o_last_reg); else n_pass++;
    i_chk_reg = 5'd4; #1;
    n_total++; if (o_hazard !== 1'b0) $display("FAIL sr_haz_r4 got=%b exp=0", o_hazard); else n_pass++;
    tick();
    i_done = 1; i_valid = 1; i_wreg = 5'd3; i_chk_reg = 5'd3; #1;
    n_total++; if (o_hazard !== 1'b1) $display("FAIL sr_haz_popcycle got=%b exp=1", o_hazard); else n_pass++;
    tick();
    idle(); i_chk_reg = 5'd3; #1;
    n_total++; if (o_outstanding !== 3'd0 || o_hazard !== 1'b0) $display("FAIL sr_drained got=%0d/%b exp=0/0", o_outstanding, o_hazard); else n_pass++;
    n_total++; if (o_read_cycle !== 1'b0) $display("FAIL sr_rc_clear got=%b exp=0", o_read_cycle); else n_pass++;
    n_total++; if (o_violation !== 1'b0) $display("FAIL sr_noviol got=%b exp=0", o_violation); else n_pass++;
  endtask

  task automatic test_fill_stall;
    do_reset();
    for (int r = 1; r <= 4; r++) begin
      i_stb = 1; i_op_read = 1; i_oreg = 5'(r);
      tick();
    end
    n_total++; if (o_outstanding !== 3'd4 || o_stall !== 1'b1) $display("FAIL fs_full got=%0d/%b exp=4/1", o_outstanding, o_stall); else n_pass++;
    n_total++; if (o_violation !== 1'b0) $display("FAIL fs_noviol_yet got=%b exp=0", o_violation); else n_pass++;
    i_oreg = 5'd5;
    tick();
    idle(); #1;
    n_total++; if (o_outstanding !== 3'd4 || o_last_reg !== 5'd4) $display("FAIL fs_rejected got=%0d/%0d exp=4/4", o_outstanding, o_last_reg); else n_pass++;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd1) $display("FAIL fs_vcode got=%b/%0d exp=1/1", o_violation, o_vcode); else n_pass++;
    for (int r = 1; r <= 4; r++) begin
      i_done = 1; i_valid = 1; i_wreg = 5'(r);
      tick();
      n_total++; if (o_outstanding !== 3'(4 - r)) $display("FAIL fs_drain%0d got=%0d exp=%0d", r, o_outstanding, 4 - r); else n_pass++;
    end
    idle(); #1;
    n_total++; if (o_busy !== 1'b0 || o_stall !== 1'b0 || o_vcode !== 3'd1) $display("FAIL fs_end got=%b/%b/%0d exp=0/0/1", o_busy, o_stall, o_vcode); else n_pass++;
  endtask

  task automatic test_bad_wreg;
    do_reset();
    i_stb = 1; i_op_read = 1; i_oreg = 5'd5;
    tick();
    idle(); i_done = 1; i_valid = 1; i_wreg = 5'd6;
    tick();
    idle(); #1;
    n_total++; if (o_outstanding !== 3'd0) $display("FAIL bw_popped got=%0d exp=0", o_outstanding); else n_pass++;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd2) $display("FAIL bw_vcode got=%b/%0d exp=1/2", o_violation, o_vcode); else n_pass++;
    i_done = 1;
    tick();
    idle(); #1;
    n_total++; if (o_vcode !== 3'd2) $display("FAIL bw_sticky got=%0d exp=2", o_vcode); else n_pass++;
  endtask

  task automatic test_pc_pending;
    do_reset();
    i_stb = 1; i_op_read = 1; i_oreg = 5'h0F;
    tick();
    idle(); #1;
    n_total++; if (o_pc_pending !== 1'b1) $display("FAIL pc_pending got=%b exp=1", o_pc_pending); else n_pass++;
    i_stb = 1; i_op_read = 1; i_oreg = 5'd2;
    tick();
    idle(); #1;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd6) $display("FAIL pc_vcode got=%b/%0d exp=1/6", o_violation, o_vcode); else n_pass++;
    n_total++; if (o_outstanding !== 3'd2 || o_pc_pending !== 1'b1) $display("FAIL pc_accepted got=%0d/%b exp=2/1", o_outstanding, o_pc_pending); else n_pass++;
  endtask

  task automatic test_back_to_back;
    do_reset();
    for (int r = 1; r <= 3; r++) begin
      i_stb = 1; i_op_read = 0; i_oreg = 5'(r);
      tick();
    end
    idle(); #1;
    n_total++; if (o_outstanding !== 3'd3 || o_rdbusy !== 1'b0 || o_busy !== 1'b1) $display("FAIL bb_three got=%0d/%b/%b exp=3/0/1", o_outstanding, o_rdbusy, o_busy); else n_pass++;
    for (int k = 0; k < 8; k++) begin
      i_stb = 1; i_op_read = (k == 4); i_oreg = 5'(8 + k); i_done = 1; i_valid = 0;
      tick();
      n_total++; if (o_outstanding !== 3'd3 || o_last_reg !== 5'(8 + k)) $display("FAIL bb_step%0d got=%0d/%0d exp=3/%0d", k, o_outstanding, o_last_reg, 8 + k); else n_pass++;
      if (k == 4) begin
        i_chk_reg = 5'd12; #1;
        n_total++; if (o_hazard !== 1'b1) $display("FAIL bb_haz12 got=%b exp=1", o_hazard); else n_pass++;
      end
    end
    idle(); #1;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd5) $display("FAIL bb_vcode got=%b/%0d exp=1/5", o_violation, o_vcode); else n_pass++;
    for (int r = 1; r <= 3; r++) begin
      i_done = 1;
      tick();
      n_total++; if (o_outstanding !== 3'(3 - r)) $display("FAIL bb_drain%0d got=%0d exp=%0d", r, o_outstanding, 3 - r); else n_pass++;
    end
    idle();
  endtask

  task automatic test_err;
    do_reset();
    for (int r = 1; r <= 2; r++) begin
      i_stb = 1; i_op_read = 1; i_oreg = 5'(r);
      tick();
    end
    idle(); i_err = 1; i_stb = 1; i_op_read = 1; i_oreg = 5'd9;
    tick();
    idle(); #1;
    n_total++; if (o_outstanding !== 3'd0 || o_read_cycle !== 1'b0 || o_busy !== 1'b0) $display("FAIL er_flush got=%0d/%b/%b exp=0/0/0", o_outstanding, o_read_cycle, o_busy); else n_pass++;
    n_total++; if (o_last_reg !== 5'd2 || o_violation !== 1'b0) $display("FAIL er_nopush got=%0d/%b exp=2/0", o_last_reg, o_violation); else n_pass++;
    i_stb = 1; i_op_read = 1; i_oreg = 5'd7;
    tick();
    idle(); #1;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd7) $display("FAIL er_vcode got=%b/%0d exp=1/7", o_violation, o_vcode); else n_pass++;
    n_total++; if (o_outstanding !== 3'd1) $display("FAIL er_accepted got=%0d exp=1", o_outstanding); else n_pass++;
    i_done = 1; tick();
    idle(); i_done = 1; tick();
    idle(); #1;
    n_total++; if (o_vcode !== 3'd7 || o_outstanding !== 3'd0) $display("FAIL er_sticky got=%0d/%0d exp=7/0", o_vcode, o_outstanding); else n_pass++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    i_stb = 1; i_op_read = 1; i_oreg = 5'd1;
    tick();
    idle(); i_reset = 1;
    tick();
    i_reset = 0; #1;
    n_total++; if (o_outstanding !== 3'd0 || o_read_cycle !== 1'b0) $display("FAIL rm_cleared got=%0d/%b exp=0/0", o_outstanding, o_read_cycle); else n_pass++;
    i_done = 1;
    tick();
    idle(); #1;
    n_total++; if (o_violation !== 1'b1 || o_vcode !== 3'd4) $display("FAIL rm_vcode got=%b/%0d exp=1/4", o_violation, o_vcode); else n_pass++;
  endtask

  initial begin
    idle();
    i_reset = 1;
    test_reset();
    test_single_read();
    test_fill_stall();
    test_bad_wreg();
    test_pc_pending();
    test_back_to_back();
    test_err();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
